// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets and
// handshake FSM state encodings.
package irq_ctrl_pkg;

    localparam logic [2:0] OFS_MASK = 3'd0;
    localparam logic [2:0] OFS_PEND = 3'd1;
    localparam logic [2:0] OFS_TRIG = 3'd2;
    localparam logic [2:0] OFS_ISR  = 3'd3;
    localparam logic [2:0] OFS_VEC  = 3'd4;
    localparam logic [2:0] OFS_EOI  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bridge register bus plus the CPU interrupt handshake seen by irq_ctrl.
interface irq_ctrl_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        cpu_ack;
    logic        int_req;

    modport master (output Addr, WE, Din, cpu_ack, input Dout, int_req);
    modport slave  (input Addr, WE, Din, cpu_ack, output Dout, int_req);
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit, plus valid.
module irq_ctrl_prio_enc #(
    parameter int NUM_SRC = 6,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = {IDX_W{1'b0}};
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx   = req[i] ? IDX_W'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: pend/mask/priority selection and a
// request/ack/EOI handshake so the CPU services one source at a time.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 6,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    irq_ctrl_if.slave          bus,
    input  logic [NUM_SRC-1:0] irq_in
);

    logic [NUM_SRC-1:0] mask_r, pend_r, trig_r, isr_r, irq_sync_r;
    logic [IDX_W-1:0]   vec_idx_r;
    logic               int_req_r;
    irq_state_e         state_r, state_next_s;

    logic [2:0]         ofs_s;
    logic               wr_mask_s, wr_pend_s, wr_trig_s, wr_eoi_s;
    logic [NUM_SRC-1:0] eligible_s, sel_onehot_s, pend_next_s, isr_next_s;
    logic [NUM_SRC-1:0] w1c_s, ack_clr_s, edge_s;
    logic [IDX_W-1:0]   sel_idx_s, vec_idx_next_s;
    logic               sel_valid_s, ack_take_s, eoi_take_s, int_req_next_s;
    logic [31:0]        dout_s;
    logic               unused_s;

    assign ofs_s     = bus.Addr[4:2];
    assign wr_mask_s = bus.WE && (ofs_s == OFS_MASK);
    assign wr_pend_s = bus.WE && (ofs_s == OFS_PEND);
    assign wr_trig_s = bus.WE && (ofs_s == OFS_TRIG);
    assign wr_eoi_s  = bus.WE && (ofs_s == OFS_EOI);
    assign unused_s  = ^{bus.Addr[31:5], bus.Din[31:NUM_SRC]};

    assign eligible_s = pend_r & mask_r & ~isr_r;

    irq_ctrl_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_prio_enc (
        .req   (eligible_s),
        .idx   (sel_idx_s),
        .valid (sel_valid_s)
    );

    assign ack_take_s = (state_r == ST_REQ) && bus.cpu_ack && sel_valid_s;
    assign eoi_take_s = (state_r == ST_SERVICE) && wr_eoi_s;

    // One-hot form of the selected source.
    always_comb begin
        sel_onehot_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_onehot_s[i] = sel_valid_s && (sel_idx_s == IDX_W'(i));
        end
    end

    // Edge bits hold until W1C or delivery, a fresh edge overriding both; level bits track the line.
    assign w1c_s       = wr_pend_s  ? bus.Din[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
    assign ack_clr_s   = ack_take_s ? sel_onehot_s        : {NUM_SRC{1'b0}};
    assign edge_s      = irq_in & ~irq_sync_r;
    assign pend_next_s = (trig_r & ((pend_r & ~w1c_s & ~ack_clr_s) | edge_s))
                       | (~trig_r & irq_in);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = sel_valid_s ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                if (!sel_valid_s) begin
                    state_next_s = ST_IDLE;
                end else if (bus.cpu_ack) begin
                    state_next_s = ST_SERVICE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                state_next_s = wr_eoi_s ? ST_IDLE : ST_SERVICE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: request line and in-service latch updates.
    always_comb begin
        int_req_next_s = (state_next_s == ST_REQ);
        isr_next_s     = isr_r;
        vec_idx_next_s = vec_idx_r;
        if (ack_take_s) begin
            isr_next_s     = sel_onehot_s;
            vec_idx_next_s = sel_idx_s;
        end else if (eoi_take_s) begin
            isr_next_s     = {NUM_SRC{1'b0}};
        end else begin
            isr_next_s     = isr_r;
        end
    end

    // Register file, sampler and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r     <= {NUM_SRC{1'b0}};
            trig_r     <= {NUM_SRC{1'b0}};
            pend_r     <= {NUM_SRC{1'b0}};
            isr_r      <= {NUM_SRC{1'b0}};
            irq_sync_r <= {NUM_SRC{1'b0}};
            vec_idx_r  <= {IDX_W{1'b0}};
            int_req_r  <= 1'b0;
        end else begin
            mask_r     <= wr_mask_s ? bus.Din[NUM_SRC-1:0] : mask_r;
            trig_r     <= wr_trig_s ? bus.Din[NUM_SRC-1:0] : trig_r;
            pend_r     <= pend_next_s;
            isr_r      <= isr_next_s;
            irq_sync_r <= irq_in;
            vec_idx_r  <= vec_idx_next_s;
            int_req_r  <= int_req_next_s;
        end
    end

    // Read-data mux.
    always_comb begin
        dout_s = 32'd0;
        case (ofs_s)
            OFS_MASK: dout_s = {{(32-NUM_SRC){1'b0}}, mask_r};
            OFS_PEND: dout_s = {{(32-NUM_SRC){1'b0}}, pend_r};
            OFS_TRIG: dout_s = {{(32-NUM_SRC){1'b0}}, trig_r};
            OFS_ISR:  dout_s = {{(32-NUM_SRC){1'b0}}, isr_r};
            OFS_VEC:  dout_s = {|isr_r, {(31-IDX_W){1'b0}}, vec_idx_r};
            default:  dout_s = 32'd0;
        endcase
    end

    assign bus.Dout    = dout_s;
    assign bus.int_req = int_req_r;

endmodule
